// File: rtl/a0_trace_logger.sv
// Change-only trace of the core's a0 register into a small FIFO drained by a ready/valid consumer.
// Optional macro A0_TRACE_OVF_EN adds the sticky overflow flag and saturating drop counter.
module a0_trace_logger #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              a0,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
`ifdef A0_TRACE_OVF_EN
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_count
`else
    output logic                     empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   last_q, last_d;
    logic          primed_q, primed_d;
    logic          capture_s, push_s, pop_s, drop_s, full_s, empty_s;

    // Capture decision, FIFO handshake and next-state computation.
    always_comb begin
        full_s    = (count_q == CNT_FULL);
        empty_s   = (count_q == {(AW+1){1'b0}});
        pop_s     = !empty_s && out_ready;
        capture_s = enable && (!primed_q || (a0 != last_q));
        // A full FIFO still accepts a sample when the head leaves in the same cycle.
        push_s    = capture_s && (!full_s || pop_s);
        drop_s    = capture_s && full_s && !pop_s;

        last_d   = last_q;
        primed_d = primed_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;

        if (capture_s) begin
            last_d   = a0;
            primed_d = 1'b1;
        end else begin
            last_d   = last_q;
            primed_d = primed_q;
        end

        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= {AW{1'b0}};
            rptr_q   <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            last_q   <= 32'h0000_0000;
            primed_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            primed_q <= primed_d;
        end
    end

    // FIFO storage; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= a0;
        end
    end

    assign out_valid = !empty_s;
    assign out_data  = mem_q[rptr_q];
    assign count     = count_q;
    assign full      = full_s;
    assign empty     = empty_s;

`ifdef A0_TRACE_OVF_EN
    logic       overflow_q;
    logic [7:0] drop_count_q;

    // Sticky overflow flag and saturating count of samples lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            drop_count_q <= 8'h00;
        end else if (drop_s) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'h01;
            end
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

endmodule

// File: tb/tb_a0_trace_logger.sv
// Self-checking bench for a0_trace_logger: vector table, directed corner sequences, random vs queue model.
module tb_a0_trace_logger;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   a0;
    logic          enable;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef A0_TRACE_OVF_EN
    logic          overflow;
    logic [7:0]    drop_count;
`endif

    always #5 clk = ~clk;

    a0_trace_logger #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a0(a0), .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full),
`ifdef A0_TRACE_OVF_EN
        .empty(empty), .overflow(overflow), .drop_count(drop_count)
`else
        .empty(empty)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: logged values as a plain queue plus the change-detect state.
    logic [31:0] mq[$];
    logic [31:0] m_last;
    bit          m_primed;
    int          m_drops;
    bit          m_ovf;

    typedef struct {
        logic        en;
        logic [31:0] a0;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        int          ec;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_last   = 32'h0;
        m_primed = 1'b0;
        m_drops  = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge: model consumes the inputs present at the edge, then inputs may change.
    task automatic tick();
        bit pop;
        bit cap;
        @(posedge clk);
        pop = (mq.size() > 0) && out_ready;
        cap = enable && (!m_primed || (a0 != m_last));
        if (pop) void'(mq.pop_front());
        if (cap) begin
            m_last   = a0;
            m_primed = 1'b1;
            if (mq.size() < DEPTH) mq.push_back(a0);
            else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        #1;
    endtask

    task automatic cmp_model();
        chk("valid", {31'h0, out_valid}, {31'h0, mq.size() != 0});
        chk("count", 32'(count), 32'(mq.size()));
        chk("full",  {31'h0, full},  {31'h0, mq.size() == DEPTH});
        chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
        if (mq.size() != 0) chk("data", out_data, mq[0]);
`ifdef A0_TRACE_OVF_EN
        chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        chk("drop_count", {24'h0, drop_count}, 32'(m_drops));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0; a0 = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full",  {31'h0, full},  32'h0);
    endtask

    initial begin
        // Per-row: inputs applied, then outputs expected before the next edge.
        tbl[0]  = '{1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 0};
        tbl[1]  = '{1'b1, 32'd0, 1'b0, 1'b1, 32'd0, 1};
        tbl[2]  = '{1'b1, 32'd0, 1'b1, 1'b1, 32'd0, 1};
        tbl[3]  = '{1'b1, 32'd5, 1'b1, 1'b0, 32'd0, 0};
        tbl[4]  = '{1'b1, 32'd5, 1'b1, 1'b1, 32'd5, 1};
        tbl[5]  = '{1'b1, 32'd7, 1'b1, 1'b0, 32'd0, 0};
        tbl[6]  = '{1'b1, 32'd7, 1'b1, 1'b1, 32'd7, 1};
        tbl[7]  = '{1'b1, 32'd7, 1'b1, 1'b0, 32'd0, 0};
        tbl[8]  = '{1'b1, 32'd9, 1'b1, 1'b0, 32'd0, 0};
        tbl[9]  = '{1'b1, 32'd9, 1'b1, 1'b1, 32'd9, 1};
        tbl[10] = '{1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 0};
        tbl[11] = '{1'b0, 32'd4, 1'b0, 1'b1, 32'd3, 1};
        tbl[12] = '{1'b0, 32'd3, 1'b0, 1'b1, 32'd3, 1};
        tbl[13] = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd3, 1};
        tbl[14] = '{1'b1, 32'd3, 1'b1, 1'b1, 32'd3, 1};
        tbl[15] = '{1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            enable = tbl[i].en; a0 = tbl[i].a0; out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ec));
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
            tick();
        end

        // Overfill with 10 distinct values, then a full-FIFO push+pop, then drain.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a0 = 32'h100 + 32'(i);
            tick();
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_full", {31'h0, full}, 32'h1);
        chk("fill_head", out_data, 32'h100);
`ifdef A0_TRACE_OVF_EN
        chk("fill_overflow", {31'h0, overflow}, 32'h1);
        chk("fill_drops", {24'h0, drop_count}, 32'd2);
`endif
        a0 = 32'hABC; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("fullpp_count", 32'(count), 32'd8);
        chk("fullpp_head", out_data, 32'h101);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("drain%0d", i), out_data, (i < 7) ? 32'h101 + 32'(i) : 32'hABC);
            tick();
        end
        #1;
        chk("drain_empty", {31'h0, empty}, 32'h1);

        // Asynchronous reset between edges with four entries queued.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a0 = 32'd10 + 32'(i);
            tick();
        end
        chk("pre_arst_count", 32'(count), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_empty", {31'h0, empty}, 32'h1);
        #1;
        rst = 1'b0;
        model_clear();
        tick();
        chk("arst_recap_count", 32'(count), 32'd1);
        chk("arst_recap_data", out_data, 32'd13);

        // Random stimulus against the queue model, slow and fast consumer phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 9) < 7);
            a0        = 32'($urandom_range(0, 5));
            out_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            cmp_model();
            tick();
        end
        #1;
        cmp_model();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/a0_trace_logger.md
A0_TRACE_LOGGER -- requirements
Module: a0_trace_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port a0  input  32  register-file a0 value sampled from the core's a0 output.
REQ-005 SHALL have port enable  input  1  capture enable; when low, no new samples are taken.
REQ-006 SHALL have port out_valid  output  1  head FIFO entry is available.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-008 SHALL have port out_data  output  32  head FIFO entry.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port empty  output  1  count == 0.

Function
REQ-012 SHALL hold a 32-bit last-value register and a primed flag, both cleared by reset.
REQ-013 SHALL raise a capture event in any cycle where enable=1 and either primed=0 or a0 != last.
REQ-014 SHALL, on a capture event, load a0 into last, set primed, and push a0 into the FIFO if it is not full.
REQ-015 SHALL update last on every capture event, including one dropped because the FIFO is full; dropped values are never retried.
REQ-016 SHALL pop the head entry at the clock edge where out_valid=1 and out_ready=1.
REQ-017 SHALL push and pop in the same cycle when the FIFO is full and a pop occurs; count stays DEPTH and the new sample is stored.
REQ-018 SHALL NOT bypass the FIFO: a sample pushed into an empty FIFO raises out_valid on the next cycle, giving 1-cycle latency from the capture cycle.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; count is exactly pushes minus pops.
REQ-021 SHALL drive out_valid = !empty and out_data = mem[read pointer]; out_data is don't-care when empty.
REQ-022 SHALL keep last and primed unchanged while enable=0; a0 changes during that time are not logged unless a0 differs from last when enable returns.
REQ-023 SHALL ignore out_ready while empty; count SHALL never underflow.

Reset
REQ-024 SHALL, while rst=1 regardless of clk, clear pointers, count, last, primed and drop state, giving out_valid=0, empty=1, full=0, count=0.
REQ-025 SHALL discard all FIFO contents on reset asserted mid-operation; out_valid SHALL fall asynchronously without waiting for a clock edge.
REQ-026 SHALL NOT require FIFO storage to be reset; out_data is unconstrained while empty.

Configuration
REQ-027 SHALL support macro A0_TRACE_OVF_EN.
REQ-028 SHALL, with A0_TRACE_OVF_EN defined, add output overflow (1, sticky) and output drop_count (8), both cleared by reset.
REQ-029 SHALL, on each capture event dropped because full with no same-cycle pop, set overflow and increment drop_count, saturating at 255.
REQ-030 SHALL, with A0_TRACE_OVF_EN undefined, omit overflow and drop_count entirely and drop samples silently; all other behaviour is identical.

Verification
REQ-031 Reset then enable=1, a0=0, out_ready=0 -> one entry 0x00000000 captured (primed rule), count=1 next cycle; a0 held at 0 -> no further entries.
REQ-032 a0 sequence 5,5,7,7,7,9 with enable=1, out_ready=1 -> out_data sequence 5,7,9, each valid one cycle after its first appearance.
REQ-033 out_ready=0, 10 distinct a0 values, DEPTH=8 -> count=8, full=1, entries are the first 8 values; with macro: overflow=1, drop_count=2.
REQ-034 FIFO full, out_ready=1 for one cycle while a new distinct a0 arrives -> count stays 8, head advances, new value stored at tail.
REQ-035 enable=0 while a0 changes 3→4→3, then enable=1 with a0=3 and last=3 -> no entry logged.
REQ-036 rst pulsed mid-clock with 4 entries queued -> out_valid=0 and count=0 immediately; next enabled cycle logs the current a0 as a primed capture.
